// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receiver: locks a local LFSR onto a 1-bit line stream,
// counts bit errors while locked and drops lock when the error density in a window is too high.
module prbs_checker #(
    parameter int                    LFSR_WIDTH  = 7,
    parameter logic [LFSR_WIDTH-1:0] TAPS        = 7'h60,
    parameter int                    LOCK_COUNT  = 16,
    parameter int                    WINDOW      = 64,
    parameter int                    UNLOCK_ERRS = 4,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ERRS_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [ERRS_W-1:0]  ERRS_LAST  = ERRS_W'(UNLOCK_ERRS - 1);

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_e;

    state_e                 state_q,     state_d;
    logic [LFSR_WIDTH-1:0]  sr_q,        sr_d;
    logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]       win_cnt_q,   win_cnt_d;
    logic [ERRS_W-1:0]      win_errs_q,  win_errs_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

    logic pred;
    logic mismatch;
    logic count_err;
    logic win_wrap;

    assign pred     = ^(sr_q & TAPS);
    assign mismatch = in ^ pred;
    assign win_wrap = (win_cnt_q == WIN_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d     = state_q;
        sr_d        = sr_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_errs_d  = win_errs_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                sr_d = {sr_q[LFSR_WIDTH-2:0], in};
                // An all-zero register predicts zeros forever, so it never counts towards lock.
                if (!mismatch && (sr_q != '0)) begin
                    if (match_cnt_q == MATCH_LAST) begin
                        state_d     = ST_LOCKED;
                        match_cnt_d = '0;
                        win_cnt_d   = '0;
                        win_errs_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                end
            end

            ST_LOCKED: begin
                sr_d        = {sr_q[LFSR_WIDTH-2:0], pred};
                win_cnt_d   = win_wrap ? '0 : win_cnt_q + 1'b1;
                err_pulse_d = mismatch;
                count_err   = mismatch;
                if (mismatch && (win_errs_q == ERRS_LAST)) begin
                    state_d     = ST_SEARCH;
                    match_cnt_d = '0;
                end else if (win_wrap) begin
                    win_errs_d = ERRS_W'(mismatch);
                end else if (mismatch) begin
                    win_errs_d = win_errs_q + 1'b1;
                end
            end

            default: state_d = ST_SEARCH;
        endcase
    end

    // A clear coinciding with a counted error restarts at one so that error is kept.
    always_comb begin
        err_count_d = err_count_q;
        if (clear) begin
            err_count_d = CNT_WIDTH'(count_err);
        end else if (count_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
